change_dispenser: RTL and testbench

Sits downstream of the change-processing stage of the automated ticketing machine. Takes the 8-bit change amount (REST) when a ticket is issued and breaks it greedily into 10-, 5- and 1-unit coins. It then drives the coin-hopper solenoids one coin at a time under a ready/pulse handshake. It reports progress to the display/controller with BUSY, remaining-coin count and a DONE pulse.

---
 rtl/change_dispenser.sv | 93 +++++++++
 tb/tb_change_dispenser.sv | 120 ++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5/1 coin split of a change amount, dispensed one solenoid pulse at a time
// Ports: i_clk clock; i_rd async active-low reset; i_start/i_rest transaction request and amount;
//        i_hopper_rdy hopper handshake; o_disp_10/o_disp_5/o_disp_1 solenoid drives;
//        o_busy transaction in progress; o_done completion pulse; o_coins_left coins still owed.
module change_dispenser #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       i_clk,
  input  logic       i_rd,
  input  logic       i_start,
  input  logic [7:0] i_rest,
  input  logic       i_hopper_rdy,
  output logic       o_disp_10,
  output logic       o_disp_5,
  output logic       o_disp_1,
  output logic       o_busy,
  output logic       o_done,
  output logic [5:0] o_coins_left
);
  typedef enum logic [2:0] {IDLE, WAIT, PULSE, GAP, DONE_S} state_t;
  localparam logic [1:0] D10 = 2'd2, D5 = 2'd1, D1 = 2'd0;
  state_t      r_state, w_next;
  logic [4:0]  r_n10;
  logic        r_n5;
  logic [2:0]  r_n1;
  logic [5:0]  r_coins;
  logic [1:0]  r_den;
  logic [15:0] r_tmr;
  logic [4:0]  w_n10;
  logic [3:0]  w_r;
  logic        w_n5;
  logic [2:0]  w_n1;
  logic [5:0]  w_total;
  logic        w_tdone;
  logic        w_timed;
  assign w_n10   = 5'(i_rest / 8'd10);
  assign w_r     = 4'(i_rest % 8'd10);
  assign w_n5    = w_r >= 4'd5;
  assign w_n1    = 3'(w_r - (w_n5 ? 4'd5 : 4'd0));
  assign w_total = 6'(w_n10) + 6'(w_n5) + 6'(w_n1);
  assign w_timed = r_state == PULSE || r_state == GAP;
  // r_tmr counts elapsed cycles of the current PULSE or GAP phase, starting at 0
  assign w_tdone = r_tmr == (r_state == PULSE ? 16'(PULSE_CYCLES - 1) : 16'(GAP_CYCLES - 1));
  always_ff @(posedge i_clk or negedge i_rd)
    if (!i_rd) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = w_total == 6'd0 ? DONE_S : WAIT;
      WAIT:    if (i_hopper_rdy) w_next = PULSE;
      PULSE:   if (w_tdone) w_next = GAP;
      GAP:     if (w_tdone) w_next = r_coins == 6'd0 ? DONE_S : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // outputs decode the state directly so a reset removes solenoid drive without waiting for a clock
  always_comb begin
    o_disp_10    = r_state == PULSE && r_den == D10;
    o_disp_5     = r_state == PULSE && r_den == D5;
    o_disp_1     = r_state == PULSE && r_den == D1;
    o_busy       = r_state == WAIT || r_state == PULSE || r_state == GAP;
    o_done       = r_state == DONE_S;
    o_coins_left = r_coins;
  end
  always_ff @(posedge i_clk or negedge i_rd)
    if (!i_rd) begin
      r_n10   <= '0;
      r_n5    <= 1'b0;
      r_n1    <= '0;
      r_coins <= '0;
      r_den   <= D1;
      r_tmr   <= '0;
    end else begin
      r_tmr <= w_timed && w_next == r_state ? r_tmr + 16'd1 : 16'd0;
      if (r_state == IDLE && i_start) begin
        r_n10   <= w_n10;
        r_n5    <= w_n5;
        r_n1    <= w_n1;
        r_coins <= w_total;
      end
      // highest nonzero denomination goes first: all tens, then the five, then ones
      if (r_state == WAIT && i_hopper_rdy)
        r_den <= r_n10 != 5'd0 ? D10 : r_n5 ? D5 : D1;
      if (r_state == PULSE && w_tdone) begin
        r_coins <= r_coins - 6'd1;
        if (r_den == D10) r_n10 <= r_n10 - 5'd1;
        else if (r_den == D5) r_n5 <= 1'b0;
        else r_n1 <= r_n1 - 3'd1;
      end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: random and directed transactions checked cycle by cycle against a coin schedule model
module tb_change_dispenser;
  localparam int MAXC = 1024;
  logic clk = 0, rd = 0, start = 0, rdy = 0;
  logic [7:0] rest = 0;
  logic [2:0] disp0, disp1;
  logic busy0, busy1, done0, done1;
  logic [5:0] coins0, coins1;
  int checks = 0, passed = 0;
  bit r_arr[MAXC];
  logic [2:0] e_disp[2][MAXC];
  bit e_busy[2][MAXC];
  bit e_done[2][MAXC];
  int e_coins[2][MAXC];
  int e_end[2];
  always #5 clk = ~clk;
  change_dispenser u0 (
    .i_clk(clk), .i_rd(rd), .i_start(start), .i_rest(rest), .i_hopper_rdy(rdy),
    .o_disp_10(disp0[2]), .o_disp_5(disp0[1]), .o_disp_1(disp0[0]),
    .o_busy(busy0), .o_done(done0), .o_coins_left(coins0));
  change_dispenser #(.PULSE_CYCLES(3), .GAP_CYCLES(2)) u1 (
    .i_clk(clk), .i_rd(rd), .i_start(start), .i_rest(rest), .i_hopper_rdy(rdy),
    .o_disp_10(disp1[2]), .o_disp_5(disp1[1]), .o_disp_1(disp1[0]),
    .o_busy(busy1), .o_done(done1), .o_coins_left(coins1));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  // schedule of a transaction accepted at edge k; index j = cycle after edge k+j, r_arr[j] = RDY sampled at edge k+j
  task automatic build(int u, int p, int g, logic [7:0] v);
    int n10, n5, n1, n, left, t, e;
    logic [2:0] d;
    n10 = v / 10;
    n5 = (v % 10) >= 5 ? 1 : 0;
    n1 = v % 10 - 5 * n5;
    n = n10 + n5 + n1;
    left = n;
    t = 0;
    for (int j = 0; j < MAXC; j++) begin
      e_disp[u][j] = 0; e_busy[u][j] = 0; e_done[u][j] = 0; e_coins[u][j] = 0;
    end
    for (int i = 0; i < n; i++) begin
      d = i < n10 ? 3'b100 : i < n10 + n5 ? 3'b010 : 3'b001;
      e = t + 1;
      while (!r_arr[e]) e++;
      for (int j = t; j < e + p + g; j++) begin
        e_busy[u][j] = 1;
        e_coins[u][j] = j < e + p ? left : left - 1;
        if (j >= e && j < e + p) e_disp[u][j] = d;
      end
      left--;
      t = e + p + g;
    end
    e_done[u][t] = 1;
    e_end[u] = t;
  endtask
  // mode 0: hopper always ready; 1: random readiness; 2: not ready for 5 cycles, then low again mid-pulse
  task automatic run(logic [7:0] v, int mode);
    int last, lo;
    for (int j = 0; j < MAXC; j++)
      r_arr[j] = mode == 0 ? 1'b1 : mode == 2 ? !((j >= 1 && j <= 5) || j == 7)
                                              : (j % 8 == 0 || $urandom % 3 != 0);
    build(0, 2, 1, v);
    build(1, 3, 2, v);
    last = e_end[0] > e_end[1] ? e_end[0] : e_end[1];
    lo = e_end[0] < e_end[1] ? e_end[0] : e_end[1];
    start = 1;
    rest = v;
    rdy = r_arr[0];
    for (int j = 0; j <= last + 1; j++) begin
      @(posedge clk);
      #1;
      check($sformatf("disp0 r%0d c%0d", v, j), 32'(disp0), 32'(e_disp[0][j]));
      check($sformatf("busy0 r%0d c%0d", v, j), 32'(busy0), 32'(e_busy[0][j]));
      check($sformatf("done0 r%0d c%0d", v, j), 32'(done0), 32'(e_done[0][j]));
      check($sformatf("coins0 r%0d c%0d", v, j), 32'(coins0), 32'(e_coins[0][j]));
      check($sformatf("disp1 r%0d c%0d", v, j), 32'(disp1), 32'(e_disp[1][j]));
      check($sformatf("busy1 r%0d c%0d", v, j), 32'(busy1), 32'(e_busy[1][j]));
      check($sformatf("done1 r%0d c%0d", v, j), 32'(done1), 32'(e_done[1][j]));
      check($sformatf("coins1 r%0d c%0d", v, j), 32'(coins1), 32'(e_coins[1][j]));
      start = (j + 1 <= lo + 1) && ($urandom % 4 == 0);
      rest = start ? 8'd99 : 8'($urandom);
      rdy = r_arr[j + 1];
    end
    start = 0;
  endtask
  initial begin
    #2;
    check("reset outs0", 32'({disp0, busy0, done0, coins0}), 32'd0);
    check("reset outs1", 32'({disp1, busy1, done1, coins1}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rd = 1;
    run(8'd7, 0);
    run(8'd37, 0);
    run(8'd0, 0);
    run(8'd255, 0);
    run(8'd15, 2);
    start = 1;
    rest = 8'd37;
    rdy = 1;
    @(posedge clk);
    #1;
    start = 0;
    @(posedge clk);
    #2;
    check("midpulse disp10", 32'(disp0), 32'b100);
    rd = 0;
    #1;
    check("async reset outs0", 32'({disp0, busy0, done0, coins0}), 32'd0);
    check("async reset outs1", 32'({disp1, busy1, done1, coins1}), 32'd0);
    @(negedge clk);
    rd = 1;
    run(8'd7, 0);
    for (int i = 0; i < 20; i++) run(8'($urandom), int'($urandom % 2));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
